// File: rtl/pipe_ctrl.sv
// pipe_ctrl: register scoreboard and stall generator beside the decode stage.
// Tracks destinations of in-flight long-latency ops and holds decode on
// RAW/WAW hazards against them, on a full scoreboard, or on an execute
// stall request. Also keeps a saturating count of stalled cycles.
module pipe_ctrl #(
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic             id_reg1_read_i,
  input  logic [4:0]       id_reg1_addr_i,
  input  logic             id_reg2_read_i,
  input  logic [4:0]       id_reg2_addr_i,
  input  logic             id_wreg_i,
  input  logic [4:0]       id_waddr_i,
  input  logic             id_long_i,
  input  logic             stallreq_ex_i,
  input  logic             done_i,
  input  logic [4:0]       done_waddr_i,
  output logic [5:0]       stall_o,
  output logic [31:0]      pending_o,
  output logic [4:0]       pend_cnt_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  localparam logic [4:0] MAX_P = 5'(MAX_PENDING);

  // stall vector encodings, bit0 = pc ... bit5 = wb
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  logic [31:0]      pending_q;
  logic [4:0]       pend_cnt_q;
  logic [CNT_W-1:0] stall_cycles_q;

  logic       raw1, raw2, waw, full, stallreq_id;
  logic       long_wr, issue, clear;
  logic [5:0] stall;

  // Hazard detection against the registered scoreboard only; a completion
  // in the current cycle is not bypassed, so release costs one extra cycle.
  always_comb begin
    raw1        = id_valid_i & id_reg1_read_i & pending_q[id_reg1_addr_i];
    raw2        = id_valid_i & id_reg2_read_i & pending_q[id_reg2_addr_i];
    waw         = id_valid_i & id_wreg_i & pending_q[id_waddr_i];
    long_wr     = id_valid_i & id_wreg_i & id_long_i & (id_waddr_i != 5'd0);
    full        = long_wr & (pend_cnt_q == MAX_P);
    stallreq_id = raw1 | raw2 | waw | full;
  end

  // Stall vector with execute requests taking priority; forced idle in reset.
  always_comb begin
    stall = STALL_NONE;
    if (rst)                stall = STALL_NONE;
    else if (stallreq_ex_i) stall = STALL_EX;
    else if (stallreq_id)   stall = STALL_ID;
  end

  // Scoreboard update events; r0 is never tracked.
  always_comb begin
    issue = long_wr & (stall == STALL_NONE);
    clear = done_i & (done_waddr_i != 5'd0) & pending_q[done_waddr_i];
  end

  // Scoreboard bits: clear first so a same-register issue leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      if (clear) pending_q[done_waddr_i] <= 1'b0;
      if (issue) pending_q[id_waddr_i]   <= 1'b1;
    end
  end

  // Occupancy count tracks the scoreboard; simultaneous issue+clear nets to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt_q <= '0;
    end else if (issue && !clear) begin
      pend_cnt_q <= pend_cnt_q + 5'd1;
    end else if (clear && !issue) begin
      pend_cnt_q <= pend_cnt_q - 5'd1;
    end
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if ((stall != STALL_NONE) && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_o        = stall;
  assign pending_o      = pending_q;
  assign pend_cnt_o     = pend_cnt_q;
  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random traffic, all
// checked each cycle against a set-based scoreboard model.
module tb_pipe_ctrl;

  localparam int MAXP  = 4;
  localparam int CW    = 6;
  localparam int SATV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid_i, id_reg1_read_i, id_reg2_read_i, id_wreg_i, id_long_i;
  logic [4:0]    id_reg1_addr_i, id_reg2_addr_i, id_waddr_i, done_waddr_i;
  logic          stallreq_ex_i, done_i;
  logic [5:0]    stall_o;
  logic [31:0]   pending_o;
  logic [4:0]    pend_cnt_o;
  logic [CW-1:0] stall_cycles_o;

  pipe_ctrl #(.MAX_PENDING(MAXP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_reg1_read_i(id_reg1_read_i), .id_reg1_addr_i(id_reg1_addr_i),
    .id_reg2_read_i(id_reg2_read_i), .id_reg2_addr_i(id_reg2_addr_i),
    .id_wreg_i(id_wreg_i), .id_waddr_i(id_waddr_i), .id_long_i(id_long_i),
    .stallreq_ex_i(stallreq_ex_i), .done_i(done_i), .done_waddr_i(done_waddr_i),
    .stall_o(stall_o), .pending_o(pending_o), .pend_cnt_o(pend_cnt_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: set of outstanding destinations and a stall tally
  logic [31:0] m_pend = '0;
  int          m_sc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; id_valid_i = 1'b0; id_reg1_read_i = 1'b0; id_reg1_addr_i = '0;
    id_reg2_read_i = 1'b0; id_reg2_addr_i = '0; id_wreg_i = 1'b0; id_waddr_i = '0;
    id_long_i = 1'b0; stallreq_ex_i = 1'b0; done_i = 1'b0; done_waddr_i = '0;
  endtask

  task automatic long_op(input logic [4:0] r);
    id_valid_i = 1'b1; id_wreg_i = 1'b1; id_long_i = 1'b1; id_waddr_i = r;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic do_cycle(input string tag);
    logic [5:0] exp_stall;
    logic       hazard, issue, clear;
    int         occupied;
    @(negedge clk);
    occupied = $countones(m_pend);
    hazard = id_valid_i && ((id_reg1_read_i && m_pend[id_reg1_addr_i]) ||
                            (id_reg2_read_i && m_pend[id_reg2_addr_i]) ||
                            (id_wreg_i && m_pend[id_waddr_i]) ||
                            (id_wreg_i && id_long_i && id_waddr_i != 0 && occupied == MAXP));
    if (rst)                exp_stall = 6'b000000;
    else if (stallreq_ex_i) exp_stall = 6'b001111;
    else if (hazard)        exp_stall = 6'b000111;
    else                    exp_stall = 6'b000000;
    chk({tag, ":stall"}, 32'(stall_o), 32'(exp_stall));
    chk({tag, ":pend"},  pending_o, m_pend);
    chk({tag, ":cnt"},   32'(pend_cnt_o), 32'(occupied));
    chk({tag, ":scyc"},  32'(stall_cycles_o), 32'(m_sc));
    issue = id_valid_i && id_wreg_i && id_long_i && id_waddr_i != 0 && exp_stall == 0;
    clear = done_i && done_waddr_i != 0 && m_pend[done_waddr_i];
    @(posedge clk);
    if (rst) begin
      m_pend = '0;
      m_sc   = 0;
    end else begin
      if (clear) m_pend[done_waddr_i] = 1'b0;
      if (issue) m_pend[id_waddr_i]   = 1'b1;
      if (exp_stall != 0 && m_sc < SATV) m_sc++;
    end
    #1;
  endtask

  task automatic reset_dut();
    idle(); rst = 1'b1;
    do_cycle("rst");
    idle();
  endtask

  initial begin
    idle(); rst = 1'b1;
    do_cycle("rst0");
    chk("rst_pend", pending_o, 32'h0);
    chk("rst_cnt", 32'(pend_cnt_o), 32'h0);
    chk("rst_scyc", 32'(stall_cycles_o), 32'h0);
    idle();

    // load r5, consumer on r5 stalls until the cycle after done
    long_op(5'd5); do_cycle("ld5");
    chk("ld5_bit", 32'(pending_o[5]), 32'h1);
    idle(); id_valid_i = 1'b1; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd5;
    do_cycle("use5a"); do_cycle("use5b");
    done_i = 1'b1; done_waddr_i = 5'd5;
    do_cycle("use5_done");
    chk("use5_cnt0", 32'(pend_cnt_o), 32'h0);
    done_i = 1'b0;
    do_cycle("use5_go");

    // fill the scoreboard then hit the full stall
    reset_dut();
    for (int r = 1; r <= 4; r++) begin
      idle(); long_op(5'(r)); do_cycle("fill");
    end
    chk("full_cnt", 32'(pend_cnt_o), 32'h4);
    idle(); long_op(5'd6);
    do_cycle("full_a"); do_cycle("full_b");
    done_i = 1'b1; done_waddr_i = 5'd2; do_cycle("full_done");
    done_i = 1'b0; do_cycle("full_issue");
    chk("full_r6", pending_o, 32'h5A);
    chk("full_cnt4", 32'(pend_cnt_o), 32'h4);

    // simultaneous clear r7 and issue r8; done on non-pending r9
    reset_dut();
    long_op(5'd7); do_cycle("iss7");
    long_op(5'd8); done_i = 1'b1; done_waddr_i = 5'd7; do_cycle("swap78");
    chk("swap_pend", pending_o, 32'h100);
    chk("swap_cnt", 32'(pend_cnt_o), 32'h1);
    idle(); done_i = 1'b1; done_waddr_i = 5'd9; do_cycle("done9");
    chk("done9_pend", pending_o, 32'h100);

    // execute stall takes priority over a RAW hazard
    reset_dut();
    long_op(5'd3); do_cycle("iss3");
    idle(); id_valid_i = 1'b1; id_reg2_read_i = 1'b1; id_reg2_addr_i = 5'd3;
    stallreq_ex_i = 1'b1; do_cycle("ex_raw");
    stallreq_ex_i = 1'b0; do_cycle("raw_only");

    // r0 never tracked, never stalls
    reset_dut();
    long_op(5'd0); id_reg1_read_i = 1'b1; id_reg2_read_i = 1'b1;
    do_cycle("r0a"); do_cycle("r0b");
    chk("r0_pend", pending_o, 32'h0);

    // reset in the middle of a stall
    reset_dut();
    long_op(5'd4); do_cycle("iss4");
    idle(); id_valid_i = 1'b1; id_reg1_read_i = 1'b1; id_reg1_addr_i = 5'd4;
    do_cycle("hold1");
    rst = 1'b1; do_cycle("hold_rst");
    chk("mrst_pend", pending_o, 32'h0);
    chk("mrst_scyc", 32'(stall_cycles_o), 32'h0);
    rst = 1'b0; do_cycle("hold3");

    // counter saturation
    reset_dut();
    stallreq_ex_i = 1'b1;
    for (int i = 0; i < SATV + 6; i++) do_cycle("sat");
    chk("sat_val", 32'(stall_cycles_o), 32'(SATV));

    // random traffic
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 59) == 0);
      id_valid_i     = ($urandom_range(0, 3) != 0);
      id_reg1_read_i = $urandom_range(0, 1) == 1;
      id_reg1_addr_i = 5'($urandom_range(0, 9));
      id_reg2_read_i = $urandom_range(0, 1) == 1;
      id_reg2_addr_i = 5'($urandom_range(0, 9));
      id_wreg_i      = ($urandom_range(0, 3) != 0);
      id_waddr_i     = 5'($urandom_range(0, 9));
      id_long_i      = $urandom_range(0, 1) == 1;
      stallreq_ex_i  = ($urandom_range(0, 7) == 0);
      done_i         = ($urandom_range(0, 2) != 0);
      done_waddr_i   = 5'($urandom_range(0, 9));
      do_cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencing controller: a register scoreboard plus stall generator sitting beside the decode stage.
- Tracks destination registers of in-flight long-latency ops (loads, multi-cycle ALU ops) that the execute/memory forwarding paths cannot cover.
- Stalls decode on RAW/WAW hazards against those registers, on a full scoreboard, or on an execute-stage stall request.
- Drives the 6-bit per-stage stall vector consumed by pc, if/id, id/ex, ex/mem, mem/wb registers, and keeps a stall-cycle performance counter.

Parameters:
- MAX_PENDING, 4, max simultaneously outstanding long-latency destinations (1..31).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high (rst == `RstEnable)
- id_valid_i  in  1  decode stage holds a real instruction
- id_reg1_read_i  in  1  decode reads source 1
- id_reg1_addr_i  in  5  source 1 register index
- id_reg2_read_i  in  1  decode reads source 2
- id_reg2_addr_i  in  5  source 2 register index
- id_wreg_i  in  1  decode instruction writes a register
- id_waddr_i  in  5  destination register index
- id_long_i  in  1  decode instruction is long-latency
- stallreq_ex_i  in  1  execute stage requests stall (multi-cycle op busy)
- done_i  in  1  a long-latency result is written back this cycle
- done_waddr_i  in  5  register completed by done_i
- stall_o  out  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold
- pending_o  out  32  scoreboard bit vector, bit0 always 0
- pend_cnt_o  out  5  number of set scoreboard bits
- stall_cycles_o  out  CNT_W  saturating count of cycles with stall_o != 0

Behaviour:
- Reset (synchronous, rst=1 at clk edge): pending_o=0, pend_cnt_o=0, stall_cycles_o=0. stall_o forced to 6'b000000 while rst=1.
- Hazard terms use registered pending_o only (no same-cycle bypass of done_i):
  - raw1 = id_valid_i & id_reg1_read_i & pending[id_reg1_addr_i]
  - raw2 = same form on source 2
  - waw = id_valid_i & id_wreg_i & pending[id_waddr_i]
  - full = id_valid_i & id_wreg_i & id_long_i & (id_waddr_i!=0) & (pend_cnt_o==MAX_PENDING)
  - stallreq_id = raw1 | raw2 | waw | full
- stall_o, combinational, priority order:
  - stallreq_ex_i=1 -> 6'b001111
  - else stallreq_id=1 -> 6'b000111
  - else 6'b000000
- issue = id_valid_i & id_wreg_i & id_long_i & (id_waddr_i!=0) & (stall_o==0).
  - On issue, pending[id_waddr_i] is set next edge.
- clear = done_i & (done_waddr_i!=0) & pending[done_waddr_i].
  - On clear, that bit is cleared next edge.
  - done_i on a non-pending register or on r0 is ignored; no counter change.
- Simultaneous issue and clear:
  - Different registers: set one, clear the other; pend_cnt unchanged.
  - Same register: bit stays 1 (new owner); pend_cnt unchanged.
- pend_cnt_o next value: +1 for issue-only, -1 for clear-only, else hold. Never exceeds MAX_PENDING (guaranteed by the full stall).
- Hazard release latency: a stalled consumer sees its bit cleared one cycle after done_i. Minimum RAW penalty is one stall cycle after completion.
- stall_cycles_o: increments each non-reset cycle with stall_o!=0; saturates at all-ones.
- Bit 0 of pending_o is never set (r0 hardwired zero); hazards on r0 never stall.
- Reset mid-stall: all scoreboard state drops; stall_o=0 from the reset cycle on.

Test Plan:
- Load r5 issued (id_long_i=1, waddr=5), next cycle consumer reads r5 (reg1) -> stall_o=6'b000111 until the cycle after done_i/done_waddr=5. pending_o bit5 set then cleared; pend_cnt 0->1->0.
- Issue long ops to r1,r2,r3,r4 with MAX_PENDING=4, then a fifth long op to r6 -> full stall (6'b000111) until any done_i. r6 then issues; pend_cnt stays 4.
- Same cycle: done_i for r7 (pending) and long issue to r8 -> bit7 cleared, bit8 set, pend_cnt unchanged. Done for r9 (not pending) -> no change.
- stallreq_ex_i=1 together with a RAW hazard -> stall_o=6'b001111. Drop stallreq_ex_i -> 6'b000111 while the hazard persists.
- Long op to r0 and reads of r0 -> pending_o stays 0, no stall.
- Hold a stall for 3 cycles, assert rst in the 2nd cycle -> stall_o=0, pending_o=0, stall_cycles_o=0 after the edge. Preload the counter to all-ones and stall -> it stays all-ones.
